// File: rtl/uart_tx_pkg.sv
// Shared types and line-mux encodings for the UART transmit controller.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  localparam logic [2:0] SEL_IDLE  = 3'd0;
  localparam logic [2:0] SEL_START = 3'd1;
  localparam logic [2:0] SEL_STP   = 3'd2;
  localparam logic [2:0] SEL_SRL   = 3'd3;
  localparam logic [2:0] SEL_PAR   = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// Frame request, serializer handshake and line outputs of the UART transmit controller.
// master = requester/serializer side, slave = the controller.
interface uart_tx_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] p_data;
  logic             data_valid;
  logic             par_en;
  logic             par_typ;
  logic             ser_data;
  logic             ser_load;
  logic             ser_en;
  logic [2:0]       mux_sel;
  logic             tx_out;
  logic             busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, ser_data,
    input  ser_load, ser_en, mux_sel, tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, ser_data,
    output ser_load, ser_en, mux_sel, tx_out, busy
  );

endinterface

// File: rtl/parity_calc.sv
// Combinational parity of a WIDTH-bit word; odd=1 inverts the even (XOR) result.
// Only compiled when UART_TX_PARITY_EN is defined.
`ifdef UART_TX_PARITY_EN
module parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             odd,
  output logic             par
);

  assign par = (^data) ^ odd;

endmodule
`endif

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, WIDTH data bits (LSB first), optional parity, stop.
// Parity support is built only with UART_TX_PARITY_EN defined.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  uart_tx_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;

  // Requests are only honoured where a new frame may begin.
  assign accept = ((state == IDLE) || (state == STOP)) && bus.data_valid;

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  logic par_q;
  logic par_en_q;

  parity_calc #(.WIDTH(WIDTH)) u_parity (
    .data (bus.p_data),
    .odd  (bus.par_typ),
    .par  (par_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else if (accept) begin
      par_q    <= par_bit;
      par_en_q <= bus.par_en;
    end
  end
`else
  logic unused_par;
  assign unused_par = bus.par_en ^ bus.par_typ;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == START)
        cnt <= '0;
      else if ((state == DATA) && (cnt != LAST))
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.ser_load = 1'b0;
    bus.ser_en   = 1'b0;
    bus.mux_sel  = SEL_IDLE;
    bus.tx_out   = 1'b1;
    bus.busy     = 1'b1;
    case (state)
      IDLE: begin
        bus.busy     = 1'b0;
        bus.ser_load = bus.data_valid;
        if (bus.data_valid)
          state_nxt = START;
      end
      START: begin
        bus.mux_sel = SEL_START;
        bus.tx_out  = 1'b0;
        state_nxt   = DATA;
      end
      DATA: begin
        bus.mux_sel = SEL_SRL;
        bus.tx_out  = bus.ser_data;
        bus.ser_en  = 1'b1;
        if (cnt == LAST) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = par_en_q ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        bus.mux_sel = SEL_PAR;
        bus.tx_out  = par_q;
        state_nxt   = STOP;
      end
`endif
      STOP: begin
        bus.mux_sel  = SEL_STP;
        bus.ser_load = bus.data_valid;
        state_nxt    = bus.data_valid ? START : IDLE;
      end
      default: begin
        bus.busy  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed scoreboard bench for uart_tx_ctrl; parity expectations follow UART_TX_PARITY_EN.
// A behavioural serializer loads on ser_load and shifts right on ser_en.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       sen;
    logic [2:0] mux;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic [WIDTH-1:0] sreg;

  uart_tx_if #(.WIDTH(WIDTH)) bus ();

  uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ser_load)
      sreg <= bus.p_data;
    else if (bus.ser_en)
      sreg <= sreg >> 1;
  end
  assign bus.ser_data = sreg[0];

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] d, input logic pe, input logic pt);
    q.push_back('{tx: 1'b0, busy: 1'b1, sen: 1'b0, mux: SEL_START});
    for (int i = 0; i < WIDTH; i++)
      q.push_back('{tx: d[i], busy: 1'b1, sen: 1'b1, mux: SEL_SRL});
`ifdef UART_TX_PARITY_EN
    if (pe)
      q.push_back('{tx: (^d) ^ pt, busy: 1'b1, sen: 1'b0, mux: SEL_PAR});
`else
    if (pe && pt) begin end
`endif
    q.push_back('{tx: 1'b1, busy: 1'b1, sen: 1'b0, mux: SEL_STP});
  endtask

  function automatic int flen(input logic pe);
`ifdef UART_TX_PARITY_EN
    return WIDTH + 2 + (pe ? 1 : 0);
`else
    return (pe === 1'bx) ? 0 : WIDTH + 2;
`endif
  endfunction

  // Called at a negedge with the controller in IDLE or STOP; returns at the START negedge.
  task automatic start_frame(input logic [WIDTH-1:0] d, input logic pe, input logic pt);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    #1;
    chk("ser_load_accept", {7'd0, bus.ser_load}, 8'd1);
    push_frame(d, pe, pt);
    cyc();
    bus.data_valid = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_empty: observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_tx"},   {7'd0, bus.tx_out},   {7'd0, e.tx});
      chk({tag, "_busy"}, {7'd0, bus.busy},     {7'd0, e.busy});
      chk({tag, "_sen"},  {7'd0, bus.ser_en},   {7'd0, e.sen});
      chk({tag, "_mux"},  {5'd0, bus.mux_sel},  {5'd0, e.mux});
      chk({tag, "_load"}, {7'd0, bus.ser_load}, 8'd0);
    end
  endtask

  task automatic pop_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      pop_one(tag);
      cyc();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   {7'd0, bus.tx_out},  8'd1);
    chk({tag, "_busy"}, {7'd0, bus.busy},    8'd0);
    chk({tag, "_sen"},  {7'd0, bus.ser_en},  8'd0);
    chk({tag, "_mux"},  {5'd0, bus.mux_sel}, {5'd0, SEL_IDLE});
  endtask

  initial begin
    rst            = 1'b1;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset_load", {7'd0, bus.ser_load}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk_idle("idle0");

    // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5, 1'b0, 1'b0);
    pop_n(flen(1'b0), "a5");
    chk_idle("a5_end");

    // 0xA5 even then odd parity; inputs scrambled right after accept
    start_frame(8'hA5, 1'b1, 1'b0);
    bus.p_data  = 8'h00;
    bus.par_typ = 1'b1;
    bus.par_en  = 1'b0;
    pop_n(flen(1'b1), "a5_even");
    chk_idle("a5_even_end");
    start_frame(8'hA5, 1'b1, 1'b1);
    bus.p_data  = 8'hFF;
    bus.par_typ = 1'b0;
    pop_n(flen(1'b1), "a5_odd");
    chk_idle("a5_odd_end");

    // Back-to-back 0x01 then 0x80, second request in STOP
    start_frame(8'h01, 1'b0, 1'b0);
    pop_n(flen(1'b0) - 1, "b2b_a");
    pop_one("b2b_a_stop");
    start_frame(8'h80, 1'b0, 1'b0);
    pop_n(flen(1'b0), "b2b_b");
    chk_idle("b2b_end");

    // Request with 0xFF during DATA of 0x00 is ignored
    start_frame(8'h00, 1'b0, 1'b0);
    pop_n(3, "ign");
    pop_one("ign_mid");
    bus.p_data     = 8'hFF;
    bus.data_valid = 1'b1;
    #1;
    chk("ign_no_load", {7'd0, bus.ser_load}, 8'd0);
    cyc();
    bus.data_valid = 1'b0;
    pop_n(flen(1'b0) - 4, "ign_rest");
    chk_idle("ign_end");

    // Async reset at DATA bit 3 of 0x3C, then a clean 0x55 frame
    start_frame(8'h3C, 1'b0, 1'b0);
    pop_n(4, "rst_pre");
    pop_one("rst_bit3");
    #2;
    rst = 1'b1;
    #1;
    chk_idle("rst_async");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk_idle("rst_after");
    start_frame(8'h55, 1'b0, 1'b0);
    pop_n(flen(1'b0), "post_rst");
    chk_idle("post_rst_end");

    // par_en=1 length: WIDTH+2 without parity build, WIDTH+3 with
    start_frame(8'hC3, 1'b1, 1'b1);
    pop_n(flen(1'b1), "len");
    chk_idle("len_end");

    chk("queue_empty", 8'(q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
